// File: rtl/serial_mouse_pkg.sv
// Shared types and constants for the Microsoft serial mouse transmitter.
// Holds the FSM state enum, ident/sync constants, frame geometry, clamp helper.
package serial_mouse_pkg;

    typedef enum logic [2:0] {
        ST_OFF,
        ST_IDGAP,
        ST_IDENT,
        ST_IDLE,
        ST_PKT0,
        ST_PKT1,
        ST_PKT2
    } state_t;

    localparam logic [6:0] MS_IDENT   = 7'h4D;
    localparam logic       MS_SYNC    = 1'b1;
    localparam int         START_BITS = 1;
    localparam int         DATA_BITS  = 7;

    // Saturate a 10-bit signed sum to the 8-bit two's complement range.
    function automatic logic [7:0] sat8(input logic signed [9:0] v);
        if (v > 10'sd127)
            return 8'h7F;
        else if (v < -10'sd128)
            return 8'h80;
        else
            return v[7:0];
    endfunction

endpackage

// File: rtl/serial_tx_7bit.sv
// 7-bit async serial transmitter: start bit, 7 data bits LSB first, stop bits.
// Ports: clk, reset, load/data (start a frame), abort (force idle, tx=1),
//        tx (line), done (last cycle of last stop bit), busy (frame in flight).
module serial_tx_7bit
    import serial_mouse_pkg::*;
#(
    parameter int BIT_CYCLES = 23864,
    parameter int STOP_BITS  = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [6:0] data,
    input  logic       abort,
    output logic       tx,
    output logic       done,
    output logic       busy
);

    localparam int FRAME_BITS = START_BITS + DATA_BITS + STOP_BITS;
    localparam int CW = $clog2(BIT_CYCLES);
    localparam int BW = $clog2(FRAME_BITS);
    localparam logic [CW-1:0] CNT_TOP = CW'(BIT_CYCLES - 1);
    localparam logic [BW-1:0] BIT_TOP = BW'(FRAME_BITS - 1);

    logic [FRAME_BITS-1:0] shreg;
    logic [CW-1:0]         cnt;
    logic [BW-1:0]         bits_left;
    logic                  active;
    logic                  bit_end;

    assign bit_end = (cnt == '0);
    // done lands in the final stop-bit cycle so a load there chains with no gap.
    assign done = active & bit_end & (bits_left == '0) & ~abort;
    assign tx   = (active & ~abort) ? shreg[0] : 1'b1;
    assign busy = active;

    always_ff @(posedge clk) begin
        if (reset || abort) begin
            active    <= 1'b0;
            shreg     <= '1;
            cnt       <= '0;
            bits_left <= '0;
        end else if (load) begin
            active    <= 1'b1;
            shreg     <= {{STOP_BITS{1'b1}}, data, 1'b0};
            cnt       <= CNT_TOP;
            bits_left <= BIT_TOP;
        end else if (active) begin
            if (bit_end) begin
                if (bits_left == '0) begin
                    active <= 1'b0;
                end else begin
                    shreg     <= {1'b1, shreg[FRAME_BITS-1:1]};
                    bits_left <= bits_left - 1'b1;
                    cnt       <= CNT_TOP;
                end
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/serial_mouse_tx.sv
// Microsoft-protocol serial mouse: accumulates motion, sends 3-byte packets.
// Ports: clk, reset, ev_strobe/ev_dx/ev_dy/ev_btn (events), rts_n (power),
//        tx (serial line, idle 1), busy (ident or packet byte in flight).
module serial_mouse_tx
    import serial_mouse_pkg::*;
#(
    parameter int BIT_CYCLES = 23864,
    parameter int STOP_BITS  = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ev_strobe,
    input  logic [7:0] ev_dx,
    input  logic [7:0] ev_dy,
    input  logic [1:0] ev_btn,
    input  logic       rts_n,
    output logic       tx,
    output logic       busy
);

    localparam int GW = $clog2(BIT_CYCLES);
    localparam logic [GW-1:0] GAP_TOP = GW'(BIT_CYCLES - 1);

    state_t            state, state_nx;
    logic              rts_q;
    logic              fall;
    logic [GW-1:0]     gap_cnt;
    logic [7:0]        acc_x, acc_y, px, py;
    logic [1:0]        btn, btn_sent;
    logic              ld, ab, done;
    logic [6:0]        ld_data;
    logic              latch, accept, pending;
    logic [7:0]        base_x, base_y;
    logic signed [9:0] sum_x, sum_y;

    assign fall    = rts_q & ~rts_n;
    assign pending = (acc_x != '0) | (acc_y != '0) | (btn != btn_sent);
    assign accept  = ev_strobe & ~rts_n &
                     (state == ST_IDLE || state == ST_PKT0 ||
                      state == ST_PKT1 || state == ST_PKT2);

    // In the latch cycle the accumulators restart from zero.
    assign base_x = latch ? 8'h00 : acc_x;
    assign base_y = latch ? 8'h00 : acc_y;
    assign sum_x  = $signed({{2{base_x[7]}}, base_x}) +
                    $signed({{2{ev_dx[7]}}, ev_dx});
    assign sum_y  = $signed({{2{base_y[7]}}, base_y}) +
                    $signed({{2{ev_dy[7]}}, ev_dy});

    always_comb begin
        state_nx = state;
        ld       = 1'b0;
        ld_data  = MS_IDENT;
        latch    = 1'b0;
        ab       = rts_n | fall;
        if (rts_n) begin
            state_nx = ST_OFF;
        end else if (fall) begin
            state_nx = ST_IDGAP;
        end else begin
            unique case (state)
                ST_OFF: ;
                ST_IDGAP:
                    if (gap_cnt == GAP_TOP) begin
                        ld       = 1'b1;
                        state_nx = ST_IDENT;
                    end
                ST_IDENT:
                    if (done) state_nx = ST_IDLE;
                ST_IDLE:
                    if (pending) begin
                        latch    = 1'b1;
                        ld       = 1'b1;
                        ld_data  = {MS_SYNC, btn, acc_y[7:6], acc_x[7:6]};
                        state_nx = ST_PKT0;
                    end
                ST_PKT0:
                    if (done) begin
                        ld       = 1'b1;
                        ld_data  = {1'b0, px[5:0]};
                        state_nx = ST_PKT1;
                    end
                ST_PKT1:
                    if (done) begin
                        ld       = 1'b1;
                        ld_data  = {1'b0, py[5:0]};
                        state_nx = ST_PKT2;
                    end
                ST_PKT2:
                    if (done) state_nx = ST_IDLE;
                default: state_nx = ST_OFF;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_OFF;
            rts_q    <= 1'b1;
            gap_cnt  <= '0;
            acc_x    <= '0;
            acc_y    <= '0;
            px       <= '0;
            py       <= '0;
            btn      <= '0;
            btn_sent <= '0;
        end else begin
            state   <= state_nx;
            rts_q   <= rts_n;
            gap_cnt <= (state == ST_IDGAP && state_nx == ST_IDGAP) ?
                       gap_cnt + 1'b1 : '0;
            if (state == ST_OFF) begin
                acc_x    <= '0;
                acc_y    <= '0;
                btn      <= '0;
                btn_sent <= '0;
            end else begin
                if (latch) begin
                    px       <= acc_x;
                    py       <= acc_y;
                    btn_sent <= btn;
                end
                if (accept) begin
                    acc_x <= sat8(sum_x);
                    acc_y <= sat8(sum_y);
                    btn   <= ev_btn;
                end else if (latch) begin
                    acc_x <= '0;
                    acc_y <= '0;
                end
            end
        end
    end

    serial_tx_7bit #(
        .BIT_CYCLES (BIT_CYCLES),
        .STOP_BITS  (STOP_BITS)
    ) u_tx (
        .clk   (clk),
        .reset (reset),
        .load  (ld),
        .data  (ld_data),
        .abort (ab),
        .tx    (tx),
        .done  (done),
        .busy  (busy)
    );

endmodule

// File: tb/tb_serial_mouse_tx.sv
// Self-checking bench for serial_mouse_tx: line receiver plus byte scoreboard.
// Expected bytes are queued as stimulus is driven and popped per decoded frame.
module tb_serial_mouse_tx;
    import serial_mouse_pkg::*;

    localparam int BC    = 16;
    localparam int FRAME = BC * 9;

    logic       clk;
    logic       reset;
    logic       ev_strobe;
    logic [7:0] ev_dx, ev_dy;
    logic [1:0] ev_btn;
    logic       rts_n;
    logic       tx, busy;

    typedef struct {
        logic [6:0] d;
        bit         b2b;
    } exp_t;

    exp_t expq[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   busy_run = 0;
    int   busy_len = 0;

    serial_mouse_tx #(
        .BIT_CYCLES (BC),
        .STOP_BITS  (1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ev_strobe (ev_strobe),
        .ev_dx     (ev_dx),
        .ev_dy     (ev_dy),
        .ev_btn    (ev_btn),
        .rts_n     (rts_n),
        .tx        (tx),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (busy) begin
            busy_run <= busy_run + 1;
        end else if (busy_run != 0) begin
            busy_len <= busy_run;
            busy_run <= 0;
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_b(input logic [6:0] d, input bit b2b);
        exp_t e;
        e.d   = d;
        e.b2b = b2b;
        expq.push_back(e);
    endtask

    task automatic push_pkt(input int x, input int y, input logic [1:0] b);
        logic [7:0] px, py;
        px = x[7:0];
        py = y[7:0];
        push_b({1'b1, b[1], b[0], py[7:6], px[7:6]}, 1'b0);
        push_b({1'b0, px[5:0]}, 1'b1);
        push_b({1'b0, py[5:0]}, 1'b1);
    endtask

    task automatic strobe(input int dx, input int dy, input logic [1:0] b);
        ev_strobe = 1'b1;
        ev_dx     = dx[7:0];
        ev_dy     = dy[7:0];
        ev_btn    = b;
        tick();
        ev_strobe = 1'b0;
    endtask

    task automatic wait_size(input string tag, input int sz, input int budget);
        int n;
        n = 0;
        while (expq.size() > sz && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk(tag, expq.size(), sz);
        #1;
    endtask

    task automatic wait_empty(input string tag, input int budget);
        wait_size(tag, 0, budget);
        repeat (20) tick();
    endtask

    // Line receiver: samples mid-bit on falling clock edges.
    initial begin
        int         start_cyc, prev_cyc;
        logic [6:0] d;
        bit         ab;
        exp_t       e;
        prev_cyc = -100000;
        d = '0;
        forever begin
            @(negedge clk);
            if (tx === 1'b0 && rts_n === 1'b0) begin
                start_cyc = cyc;
                ab = 1'b0;
                repeat (BC / 2 - 1) @(negedge clk);
                if (rts_n) ab = 1'b1;
                else chk("start_bit", tx, 0);
                for (int i = 0; i < 7 && !ab; i++) begin
                    repeat (BC) @(negedge clk);
                    if (rts_n) ab = 1'b1;
                    else d[i] = tx;
                end
                if (!ab) begin
                    repeat (BC) @(negedge clk);
                    if (rts_n) ab = 1'b1;
                    else chk("stop_bit", tx, 1);
                end
                if (!ab) begin
                    chk("frame_expected", int'(expq.size() != 0), 1);
                    if (expq.size() != 0) begin
                        e = expq.pop_front();
                        chk("byte", d, e.d);
                        if (e.b2b) chk("b2b_gap", start_cyc - prev_cyc, FRAME);
                    end
                    prev_cyc = start_cyc;
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n, low, bz;
        reset = 1'b1;
        ev_strobe = 1'b0;
        ev_dx = '0;
        ev_dy = '0;
        ev_btn = '0;
        rts_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("reset_tx", tx, 1);
        chk("reset_busy", busy, 0);
        tick();

        // powered off: events ignored, line stays mark
        strobe(5, 0, 2'b00);
        low = 0;
        bz = 0;
        repeat (2000) begin
            @(negedge clk);
            if (tx !== 1'b1) low++;
            if (busy !== 1'b0) bz++;
        end
        chk("off_tx_low", low, 0);
        chk("off_busy", bz, 0);
        tick();

        // ident after RTS falls
        push_b(MS_IDENT, 1'b0);
        rts_n = 1'b0;
        @(posedge clk);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (tx !== 1'b0 && n < 100);
        chk("ident_gap", n, BC);
        wait_empty("ident_rx", 400);
        chk("ident_busy", busy_len, FRAME);

        // single packet, one-cycle latency, back-to-back bytes
        push_pkt(5, -3, 2'b10);
        strobe(5, -3, 2'b10);
        @(negedge clk);
        chk("pkt_lat0", tx, 1);
        tick();
        @(negedge clk);
        chk("pkt_lat1", tx, 0);
        wait_empty("pkt3", 800);
        chk("pkt3_busy", busy_len, 3 * FRAME);

        // saturation: +200 -> 127, -200 -> -128
        push_pkt(1, 0, 2'b00);
        strobe(1, 0, 2'b00);
        repeat (30) tick();
        strobe(100, 0, 2'b00);
        strobe(100, 0, 2'b00);
        push_pkt(127, 0, 2'b00);
        wait_size("pkt4_a", 3, 1000);
        repeat (40) tick();
        strobe(-100, 0, 2'b00);
        strobe(-100, 0, 2'b00);
        push_pkt(-128, 0, 2'b00);
        wait_empty("pkt4", 3000);

        // abort mid-b1, then fresh ident with motion discarded
        push_pkt(9, 0, 2'b00);
        strobe(9, 0, 2'b00);
        wait_size("pkt5_b0", 2, 1000);
        repeat (40) tick();
        strobe(7, 0, 2'b00);
        rts_n = 1'b1;
        expq.delete();
        @(negedge clk);
        chk("abort_tx", tx, 1);
        tick();
        @(negedge clk);
        chk("abort_busy", busy, 0);
        repeat (20) tick();
        push_b(MS_IDENT, 1'b0);
        rts_n = 1'b0;
        wait_empty("ident2", 600);
        repeat (600) tick();

        // strobe in latch cycle carried into next packet
        push_pkt(1, 0, 2'b00);
        push_pkt(5, 0, 2'b00);
        strobe(1, 0, 2'b00);
        strobe(3, 0, 2'b00);
        repeat (50) tick();
        strobe(2, 0, 2'b00);
        wait_empty("pkt6", 3000);

        repeat (300) tick();
        chk("queue_drained", expq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
